argmax_onehot: RTL
==================

Name: argmax_onehot

Overview:
- Upstream stage of the seven-segment display path: consumes the 10 class scores streamed from the network output layer and selects the largest.
- Emits the winning class as a 10-bit one-hot `digit` plus a one-cycle `display_EN` pulse, both wired directly to the display block.
- One-hot convention: `digit[9]` = class 0 … `digit[0]` = class 9.

Parameters:
- SCORE_W, 16, width of each signed two's-complement score.
- NUM_CLASSES, 10, classes per frame; fixed at 10 by the display encoding.
- CONF_THRESH, 0, signed threshold used only when the optional feature is compiled in.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset
- clear  input  1  synchronous frame abort
- score_valid  input  1  score_data valid
- score_ready  output  1  block accepts score this cycle
- score_data  input  SCORE_W  signed class score, classes presented in order 0..9
- digit  output  10  one-hot winning class
- display_EN  output  1  one-cycle pulse, new digit valid
- busy  output  1  frame in progress
- class_idx  output  4  binary index of winner

Interface: one clock `clk`; reset `rst_n` is asynchronous, active-low.

Behaviour:
- Reset values (async, on `rst_n` low):
  - FSM → IDLE.
  - `score_ready` = 1, `digit` = 0, `display_EN` = 0, `busy` = 0, `class_idx` = 0.
  - Internal index, best value and best index = 0.
- Handshake: a score is accepted when `score_valid && score_ready`. Upstream holds `score_data` stable while `score_valid` is high and `score_ready` is low.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - `score_ready` = 1.
  - On accept: best value ← score, best index ← 0, index ← 1, go to ACCUM, `busy` = 1.
- ACCUM:
  - `score_ready` = 1.
  - On accept: if score > best value (signed, strict), best value ← score and best index ← index; index ← index + 1.
  - On the accept where index = 9, go to DONE.
- DONE (exactly one cycle):
  - `score_ready` = 0.
  - `digit` ← `1 << (9 - best index)`, `class_idx` ← best index.
  - `display_EN` = 1 for this cycle only; `busy` = 0 from the next cycle.
  - Next state is IDLE.
- Latency: `display_EN` is registered high in the cycle immediately after the 10th accepted score.
- Throughput: one frame per 11 cycles minimum.
- Ties: the lowest class index wins (strict-greater compare).
- Extremes: the most-negative score (-2^(SCORE_W-1)) is a legal score. A frame of ten equal scores yields class 0.
- Hold: `digit` and `class_idx` hold their last result until the next DONE and are unaffected by IDLE or ACCUM.
- Gaps: `score_valid` gaps inside a frame are allowed; the block stays in ACCUM indefinitely and has no timeout.
- `clear`:
  - Highest priority after reset.
  - In IDLE or ACCUM: discard the partial frame, index ← 0, go to IDLE, `busy` = 0.
  - A score presented in the same cycle is not accepted (`score_ready` is forced to 0 while `clear` = 1).
  - In DONE: the DONE outputs still complete (`display_EN` pulses), then go to IDLE.
  - `digit` is never cleared by `clear`.
- Reset mid-frame: all state is lost and no `display_EN` is issued.

Optional Feature:
- Macro: ARGMAX_CONF_CHECK_EN.
- Defined:
  - In DONE, if best value <= CONF_THRESH (signed), `digit` ← 10'b0 (display blanks) and `class_idx` ← 4'hF.
  - `display_EN` still pulses.
- Undefined:
  - CONF_THRESH is ignored and the winner is always reported.

Decomposition:
- Shared package `argmax_pkg`:
  - NUM_CLASSES.
  - State encoding typedef (IDLE/ACCUM/DONE).
  - Index width constant (4).
  - Function mapping a binary index to the display one-hot (`1 << (9 - idx)`), reused by the bench.
- One sub-module is natural: `argmax_cmp`, a combinational signed compare/select (value + index in, updated best out), keeping the FSM file minimal.

Test Plan:
- Scores 0..9 = {5,3,9,-2,9,0,1,1,7,-8}, valid every cycle → `display_EN` one cycle after the 10th score; `digit` = 10'b0010000000, `class_idx` = 2 (tie at 9 resolves to lower index).
- All ten scores = -32768 → `digit` = 10'b1000000000, `class_idx` = 0; `score_ready` low only in the DONE cycle.
- Scores {-1,…,-1,100} with random `score_valid` gaps → `digit` = 10'b0000000001, `class_idx` = 9; no early `display_EN`.
- Five scores, then `clear` with `score_valid` high; then a full frame with maximum at class 4 → the `clear`-cycle score is not accepted; a single `display_EN`, `digit` = 10'b0000100000; the previous `digit` is held until then.
- Assert `rst_n` low after the 6th score → outputs at reset values immediately (async); the next full frame, maximum at class 7, gives `digit` = 10'b0000000100.
- With ARGMAX_CONF_CHECK_EN and CONF_THRESH = 10, all scores ≤ 10 → `digit` = 0, `class_idx` = 15, `display_EN` pulses; without the macro the same stimulus reports the argmax.

Source files
------------

// File: rtl/argmax_pkg.sv
// -----------------------------------------------------------------------------
// argmax_pkg
// Shared definitions for the argmax_onehot block and its bench:
//   NUM_CLASSES   - classes per frame (fixed at 10 by the display encoding)
//   IDX_W         - width of a class index
//   state_t       - FSM state encoding (ST_IDLE / ST_ACCUM / ST_DONE)
//   idx_to_onehot - binary class index -> display one-hot (class 0 = bit 9)
// -----------------------------------------------------------------------------
package argmax_pkg;

    localparam int NUM_CLASSES = 10;
    localparam int IDX_W       = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ACCUM = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

    // Display wiring is reversed: class 0 drives digit[9], class 9 drives digit[0].
    // Indices outside 0..9 map to an all-zero (blank) pattern.
    function automatic logic [9:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [9:0] oh;
        oh = '0;
        if (idx <= 4'd9) begin
            oh[4'd9 - idx] = 1'b1;
        end
        return oh;
    endfunction

endpackage

// File: rtl/argmax_cmp.sv
// -----------------------------------------------------------------------------
// argmax_cmp
// Combinational compare/select step of the running argmax.
//   score    (in)  - candidate score, signed
//   idx      (in)  - class index of the candidate
//   best_val (in)  - current best score, signed
//   best_idx (in)  - class index of the current best
//   new_val  (out) - updated best score
//   new_idx  (out) - updated best index
// A strict greater-than keeps the earlier (lower) index on ties.
// -----------------------------------------------------------------------------
module argmax_cmp
    import argmax_pkg::*;
#(
    parameter int SCORE_W = 16
) (
    input  logic signed [SCORE_W-1:0] score,
    input  logic        [IDX_W-1:0]   idx,
    input  logic signed [SCORE_W-1:0] best_val,
    input  logic        [IDX_W-1:0]   best_idx,
    output logic signed [SCORE_W-1:0] new_val,
    output logic        [IDX_W-1:0]   new_idx
);

    always_comb begin
        new_val = best_val;
        new_idx = best_idx;
        if (score > best_val) begin
            new_val = score;
            new_idx = idx;
        end
    end

endmodule

// File: rtl/argmax_onehot.sv
// -----------------------------------------------------------------------------
// argmax_onehot
// Consumes the 10 class scores of a frame (class 0 first) and reports the
// class with the largest signed score as a one-hot digit for the display.
//   clk          (in)  - system clock
//   rst_n        (in)  - asynchronous active-low reset
//   clear        (in)  - synchronous frame abort; blocks acceptance this cycle
//   score_valid  (in)  - score_data valid
//   score_ready  (out) - block accepts a score this cycle
//   score_data   (in)  - signed class score
//   digit        (out) - one-hot winner, class 0 = digit[9]; held between frames
//   display_EN   (out) - one-cycle pulse, new digit valid
//   busy         (out) - frame in progress (including the result cycle)
//   class_idx    (out) - binary winner index; held between frames
// Optional build macro ARGMAX_CONF_CHECK_EN: when defined, a winner whose score
// is <= CONF_THRESH blanks the display (digit = 0, class_idx = 4'hF).
// -----------------------------------------------------------------------------
module argmax_onehot
    import argmax_pkg::*;
#(
    parameter int                        SCORE_W     = 16,
    parameter int                        NUM_CLASSES = argmax_pkg::NUM_CLASSES,
    parameter logic signed [SCORE_W-1:0] CONF_THRESH = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic                      score_valid,
    output logic                      score_ready,
    input  logic signed [SCORE_W-1:0] score_data,
    output logic [9:0]                digit,
    output logic                      display_EN,
    output logic                      busy,
    output logic [IDX_W-1:0]          class_idx
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    state_t                    state_q,      state_d;
    logic        [IDX_W-1:0]   idx_q,        idx_d;
    logic signed [SCORE_W-1:0] best_val_q,   best_val_d;
    logic        [IDX_W-1:0]   best_idx_q,   best_idx_d;
    logic        [9:0]         digit_q,      digit_d;
    logic        [IDX_W-1:0]   class_idx_q,  class_idx_d;
    logic                      display_en_q, display_en_d;

    logic                      accept;
    logic signed [SCORE_W-1:0] cmp_val;
    logic        [IDX_W-1:0]   cmp_idx;
    logic                      conf_pass;

    argmax_cmp #(
        .SCORE_W (SCORE_W)
    ) u_cmp (
        .score    (score_data),
        .idx      (idx_q),
        .best_val (best_val_q),
        .best_idx (best_idx_q),
        .new_val  (cmp_val),
        .new_idx  (cmp_idx)
    );

`ifdef ARGMAX_CONF_CHECK_EN
    // Judged on the final best value, i.e. the compare result of the 10th score.
    assign conf_pass = (cmp_val > CONF_THRESH);
`else
    assign conf_pass = 1'b1;
    logic unused_conf_thresh;
    assign unused_conf_thresh = ^CONF_THRESH;
`endif

    assign score_ready = (state_q != ST_DONE) && !clear;
    assign accept      = score_valid && score_ready;

    assign busy        = (state_q != ST_IDLE);
    assign display_EN  = display_en_q;
    assign digit       = digit_q;
    assign class_idx   = class_idx_q;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        best_val_d   = best_val_q;
        best_idx_d   = best_idx_q;
        digit_d      = digit_q;
        class_idx_d  = class_idx_q;
        display_en_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (clear) begin
                    idx_d = '0;
                end else if (accept) begin
                    best_val_d = score_data;
                    best_idx_d = '0;
                    idx_d      = IDX_W'(1);
                    state_d    = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (clear) begin
                    idx_d   = '0;
                    state_d = ST_IDLE;
                end else if (accept) begin
                    best_val_d = cmp_val;
                    best_idx_d = cmp_idx;
                    idx_d      = idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        // Result is registered now so that digit/class_idx and
                        // display_EN all appear together in the DONE cycle.
                        idx_d        = '0;
                        state_d      = ST_DONE;
                        display_en_d = 1'b1;
                        if (conf_pass) begin
                            digit_d     = idx_to_onehot(cmp_idx);
                            class_idx_d = cmp_idx;
                        end else begin
                            digit_d     = '0;
                            class_idx_d = '1;
                        end
                    end
                end
            end
            ST_DONE: begin
                // The result is already latched; clear here only affects
                // acceptance, the pulse still completes.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            best_val_q   <= '0;
            best_idx_q   <= '0;
            digit_q      <= '0;
            class_idx_q  <= '0;
            display_en_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            best_val_q   <= best_val_d;
            best_idx_q   <= best_idx_d;
            digit_q      <= digit_d;
            class_idx_q  <= class_idx_d;
            display_en_q <= display_en_d;
        end
    end

endmodule
